// File: rtl/afifo_rd_stream_adapter.sv
// afifo_rd_stream_adapter: turns the async FIFO's fixed-latency read port into a valid/ready stream
// Build option: define AFIFO_RD_STREAM_LAST_EN to compile in burst framing (m_last/pkt_active).
// Ports:
//   rd_clk, rd_rst          read-domain clock, synchronous active-high reset
//   fifo_rd_en              FIFO read enable (issued only when buffer credit is available)
//   fifo_rd_empty           FIFO empty flag
//   fifo_rd_data            FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   m_data/m_valid/m_ready  downstream stream, head of the prefetch buffer
//   m_last/pkt_active       burst framing (tied to 0 when framing is not built)
//   xfer_cnt                accepted beats since reset, wraps at 2^32
module afifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int BURST_LEN  = 256
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  pkt_active,
    output logic [31:0]           xfer_cnt
);
    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         buf_cnt_q, buf_cnt_d, inflight_cnt;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [31:0]           xfer_cnt_q, xfer_cnt_d;
    logic                  push, pop;

    // Credit counts both buffered words and reads still in the FIFO pipeline,
    // so a word returning from the FIFO always has a free buffer slot.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
        push = inflight_q[RD_LATENCY-1];
        m_valid = buf_cnt_q != '0;
        pop = m_valid && m_ready;
        fifo_rd_en = !rd_rst && !fifo_rd_empty && ({1'b0, buf_cnt_q} + {1'b0, inflight_cnt} < CW1'(BUF_DEPTH));
        buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
        inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});
        wr_ptr_d = push ? (wr_ptr_q == PW'(BUF_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == PW'(BUF_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        xfer_cnt_d = xfer_cnt_q + 32'(pop);
    end

    assign m_data   = buf_q[rd_ptr_q];
    assign xfer_cnt = xfer_cnt_q;

    // Clearing the in-flight tracker on reset discards data of reads issued before reset.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            buf_cnt_q  <= '0;
            inflight_q <= '0;
            xfer_cnt_q <= '0;
        end else begin
            if (push) buf_q[wr_ptr_q] <= fifo_rd_data;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

`ifdef AFIFO_RD_STREAM_LAST_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] beat_q, beat_d;

    // With BURST_LEN=1 every beat carries m_last, so the FSM never leaves IDLE.
    always_comb begin
        m_last  = m_valid && (beat_q == 16'(BURST_LEN - 1));
        beat_d  = pop ? (m_last ? '0 : beat_q + 16'd1) : beat_q;
        state_d = pop ? (m_last ? S_IDLE : S_BURST) : state_q;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign pkt_active = state_q == S_BURST;
`else
    assign m_last     = 1'b0;
    assign pkt_active = 1'b0;
`endif
endmodule

// File: tb/tb_afifo_rd_stream_adapter.sv
// tb_afifo_rd_stream_adapter: randomized bench with a FIFO model and an in-order word scoreboard
module tb_afifo_rd_stream_adapter;
    localparam int DW = 16;
    localparam int LAT = 2;
    localparam int BL = 4;
    localparam int DEPTH = LAT + 2;
`ifdef AFIFO_RD_STREAM_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          fifo_rd_en, fifo_rd_empty, m_valid, m_last, pkt_active;
    logic          m_ready = 1'b0;
    logic [DW-1:0] fifo_rd_data, m_data;
    logic [31:0]   xfer_cnt;

    always #5 clk = ~clk;

    afifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(LAT), .BURST_LEN(BL)) dut (
        .rd_clk(clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data(fifo_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .pkt_active(pkt_active), .xfer_cnt(xfer_cnt)
    );

    // FIFO model: data appears exactly LAT cycles after the read is sampled
    logic [DW-1:0] mem [2048];
    logic [DW-1:0] pipe [LAT];
    int            wptr = 0;
    int            rptr = 0;
    logic          hold = 1'b0;

    assign fifo_rd_empty = (rptr == wptr) || hold;
    assign fifo_rd_data  = pipe[LAT-1];

    always @(posedge clk) begin
        pipe[0] <= fifo_rd_en ? mem[rptr] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (fifo_rd_en) rptr <= rptr + 1;
    end

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            out = 0;
    int            first_x, last_x;
    int            e_data, e_en, e_stab, e_last, e_pkt, e_xc, limit_hits;
    logic [31:0]   nbeats = 0;
    bit            armed = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    bit            nx_ready = 0, nx_hold = 0, nx_rst = 1;
    logic [DW-1:0] exp_q[$], load_q[$], got_q[$];
    bit            last_q[$];

    task automatic tick();
        bit x;
        bit en_exp;
        @(negedge clk);
        m_ready = nx_ready;
        hold = nx_hold;
        rd_rst = nx_rst;
        while (load_q.size() != 0) begin
            mem[wptr] = load_q[0];
            exp_q.push_back(load_q.pop_front());
            wptr++;
        end
        #1;
        cyc++;
        x = m_valid && m_ready && !rd_rst;
        if (armed) begin
            en_exp = !rd_rst && !fifo_rd_empty && out < DEPTH;
            if (fifo_rd_en !== en_exp) e_en++;
            if (!rd_rst && !fifo_rd_empty && out == DEPTH && fifo_rd_en === 1'b0) limit_hits++;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) e_stab++;
            if (m_last !== (LAST_ON && m_valid && (nbeats % BL == BL - 1))) e_last++;
            if (pkt_active !== (LAST_ON && (nbeats % BL != 0))) e_pkt++;
            if (xfer_cnt !== nbeats) e_xc++;
            if (x) begin
                if (exp_q.size() == 0 || m_data !== exp_q[0]) e_data++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got_q.push_back(m_data);
                last_q.push_back(m_last);
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                nbeats++;
            end
        end
        out = out + int'(fifo_rd_en === 1'b1) - int'(x);
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        if (rd_rst) begin
            for (int i = 0; i < out; i++) if (exp_q.size() != 0) void'(exp_q.pop_front());
            out = 0;
            nbeats = 0;
            prev_stall = 0;
            armed = 1;
        end
    endtask

    task automatic start();
        nx_rst = 1;
        nx_ready = 0;
        nx_hold = 0;
        tick();
        nx_rst = 0;
        e_data = 0; e_en = 0; e_stab = 0; e_last = 0; e_pkt = 0; e_xc = 0; limit_hits = 0;
        got_q.delete();
        last_q.delete();
        first_x = -1;
        last_x = -1;
    endtask

    task automatic test_reset();
        nx_rst = 1;
        repeat (3) tick();
        nx_rst = 0;
        tick();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (pkt_active !== 1'b0) begin failures++; $display("FAIL reset_pkt_active got=%b exp=0", pkt_active); end
        checks++; if (xfer_cnt !== 32'd0) begin failures++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
        checks++; if (m_data !== 16'd0) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    endtask

    task automatic test_stream();
        int mism = 0;
        start();
        nx_ready = 1;
        for (int i = 1; i <= 8; i++) load_q.push_back(16'(i));
        for (int c = 0; c < 40 && got_q.size() < 8; c++) tick();
        tick();
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(i + 1)) mism++;
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got_q.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL stream_order bad=%0d exp=0", mism); end
        checks++; if (last_x - first_x != 7) begin failures++; $display("FAIL stream_gapless span=%0d exp=7", last_x - first_x); end
        checks++; if (xfer_cnt !== 32'd8) begin failures++; $display("FAIL stream_xfer_cnt got=%0d exp=8", xfer_cnt); end
        checks++; if (e_en + e_xc + e_stab != 0) begin failures++; $display("FAIL stream_protocol errs=%0d exp=0", e_en + e_xc + e_stab); end
    endtask

    task automatic test_latency();
        int t_en = -1;
        int t_v = -1;
        start();
        nx_ready = 1;
        for (int i = 0; i < 64; i++) load_q.push_back(16'($urandom));
        for (int c = 0; c < 300 && got_q.size() < 64; c++) begin
            tick();
            if (fifo_rd_en === 1'b1 && t_en < 0) t_en = cyc;
            if (m_valid === 1'b1 && t_v < 0) t_v = cyc;
        end
        checks++; if (t_v - t_en != LAT + 1) begin failures++; $display("FAIL latency_first_valid got=%0d exp=%0d", t_v - t_en, LAT + 1); end
        checks++; if (got_q.size() != 64 || last_x - first_x != 63) begin failures++; $display("FAIL latency_gapless beats=%0d span=%0d exp=64/63", got_q.size(), last_x - first_x); end
        checks++; if (e_data != 0) begin failures++; $display("FAIL latency_data bad=%0d exp=0", e_data); end
        checks++; if (e_en != 0) begin failures++; $display("FAIL latency_credit bad=%0d exp=0", e_en); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int mism = 0;
        start();
        for (int i = 1; i <= 32; i++) load_q.push_back(16'(i));
        for (int c = 0; c < 600 && got_q.size() < 32; c++) begin
            nx_ready = pat[c % 4];
            tick();
        end
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(i + 1)) mism++;
        checks++; if (got_q.size() != 32) begin failures++; $display("FAIL bp_count got=%0d exp=32", got_q.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL bp_order bad=%0d exp=0", mism); end
        checks++; if (e_stab != 0) begin failures++; $display("FAIL bp_stable bad=%0d exp=0", e_stab); end
        checks++; if (e_en != 0) begin failures++; $display("FAIL bp_issue bad=%0d exp=0", e_en); end
        checks++; if (limit_hits == 0) begin failures++; $display("FAIL bp_credit_limit hits=%0d exp>0", limit_hits); end
    endtask

    task automatic test_framing();
        int mism = 0;
        int nlast = 0;
        start();
        nx_ready = 1;
        for (int i = 1; i <= 10; i++) load_q.push_back(16'(16'h100 + i));
        for (int c = 0; c < 60 && got_q.size() < 10; c++) tick();
        tick();
        for (int i = 0; i < last_q.size(); i++) begin
            if (last_q[i] !== (LAST_ON && (i % BL == BL - 1))) mism++;
            nlast += int'(last_q[i]);
        end
        checks++; if (mism != 0 || last_q.size() != 10) begin failures++; $display("FAIL frame_last_pos bad=%0d beats=%0d exp=0/10", mism, last_q.size()); end
        checks++; if (nlast != (LAST_ON ? 2 : 0)) begin failures++; $display("FAIL frame_last_count got=%0d exp=%0d", nlast, LAST_ON ? 2 : 0); end
        checks++; if (pkt_active !== LAST_ON) begin failures++; $display("FAIL frame_pkt_active got=%b exp=%b", pkt_active, LAST_ON); end
        checks++; if (e_last + e_pkt != 0) begin failures++; $display("FAIL frame_cycle errs=%0d exp=0", e_last + e_pkt); end
    endtask

    task automatic test_empty_refill();
        int mism = 0;
        int en_cnt = 0;
        start();
        nx_ready = 1;
        for (int i = 1; i <= 3; i++) load_q.push_back(16'(16'h300 + i));
        repeat (12) tick();
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL empty_drain got=%0d exp=3", got_q.size()); end
        checks++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin failures++; $display("FAIL empty_idle valid=%b rd_en=%b exp=0/0", m_valid, fifo_rd_en); end
        nx_hold = 1;
        for (int i = 4; i <= 8; i++) load_q.push_back(16'(16'h300 + i));
        repeat (6) begin
            tick();
            en_cnt += int'(fifo_rd_en === 1'b1);
        end
        checks++; if (en_cnt != 0 || got_q.size() != 3) begin failures++; $display("FAIL empty_hold rd_en_cycles=%0d beats=%0d exp=0/3", en_cnt, got_q.size()); end
        nx_hold = 0;
        for (int c = 0; c < 40 && got_q.size() < 8; c++) tick();
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(16'h301 + i)) mism++;
        checks++; if (got_q.size() != 8 || mism != 0) begin failures++; $display("FAIL empty_resume beats=%0d bad=%0d exp=8/0", got_q.size(), mism); end
        checks++; if (e_en + e_data != 0) begin failures++; $display("FAIL empty_rules errs=%0d exp=0", e_en + e_data); end
    endtask

    task automatic test_reset_midstream();
        int mism = 0;
        start();
        for (int i = 1; i <= 10; i++) load_q.push_back(16'(16'h200 + i));
        for (int c = 0; c < 20 && out != DEPTH; c++) tick();
        nx_rst = 1;
        tick();
        nx_rst = 0;
        tick();
        checks++; if (m_valid !== 1'b0 || m_data !== 16'd0) begin failures++; $display("FAIL rst_mid_valid valid=%b data=%h exp=0/0000", m_valid, m_data); end
        checks++; if (xfer_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_xfer_cnt got=%0d exp=0", xfer_cnt); end
        nx_ready = 1;
        for (int c = 0; c < 40 && got_q.size() < 6; c++) tick();
        repeat (6) tick();
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(16'h205 + i)) mism++;
        checks++; if (got_q.size() != 6) begin failures++; $display("FAIL rst_mid_count got=%0d exp=6", got_q.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL rst_mid_stale bad=%0d exp=0", mism); end
        checks++; if (xfer_cnt !== 32'd6) begin failures++; $display("FAIL rst_mid_count_after got=%0d exp=6", xfer_cnt); end
    endtask

    task automatic test_random();
        int loaded = 0;
        int n;
        start();
        for (int c = 0; c < 4000 && got_q.size() < 150; c++) begin
            if (loaded < 150 && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 5);
                if (n > 150 - loaded) n = 150 - loaded;
                for (int i = 0; i < n; i++) load_q.push_back(16'($urandom));
                loaded += n;
            end
            nx_ready = $urandom_range(0, 3) != 0;
            nx_hold = $urandom_range(0, 7) == 0;
            tick();
        end
        nx_hold = 0;
        checks++; if (got_q.size() != 150) begin failures++; $display("FAIL rand_count got=%0d exp=150", got_q.size()); end
        checks++; if (e_data != 0) begin failures++; $display("FAIL rand_data bad=%0d exp=0", e_data); end
        checks++; if (e_en != 0) begin failures++; $display("FAIL rand_issue bad=%0d exp=0", e_en); end
        checks++; if (e_stab != 0) begin failures++; $display("FAIL rand_stable bad=%0d exp=0", e_stab); end
        checks++; if (e_xc != 0) begin failures++; $display("FAIL rand_xfer_cnt bad=%0d exp=0", e_xc); end
        checks++; if (e_last + e_pkt != 0) begin failures++; $display("FAIL rand_framing bad=%0d exp=0", e_last + e_pkt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_backpressure();
        test_framing();
        test_empty_refill();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
